// File: rtl/bcd_hex_display_pkg.sv
// Shared types and constants for the millisecond BCD display block:
// FSM state encoding, saturation limit and seven-segment patterns.
package bcd_hex_display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } state_t;

    localparam logic [19:0] MAX_DISPLAY = 20'd999999;
    localparam int unsigned SHIFT_COUNT = 20;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

endpackage

// File: rtl/bcd_hex_display_seg7_decode.sv
// Combinational BCD digit to active-low seven-segment pattern decoder.
// Non-decimal nibbles render as blank.
module seg7_decode
    import bcd_hex_display_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        unique case (i_digit)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_hex_display.sv
// Converts a saturated 20-bit millisecond count to six BCD digits with a
// serial double-dabble and latches the segment patterns onto hex0..hex5.
module bcd_hex_display
    import bcd_hex_display_pkg::*;
#(
    parameter int BLANK_LZ = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [19:0] value,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5
);

    state_t      r_state;
    state_t      w_next_state;
    logic [19:0] r_bin;
    logic [23:0] r_bcd;
    logic [4:0]  r_cnt;
    logic        r_ovf_next;
    logic        r_busy;
    logic        r_done;
    logic        r_ovf;
    logic [6:0]  r_hex [6];

    logic [23:0] w_bcd_adj;
    logic [3:0]  w_nib;
    logic [5:0]  w_lz;
    logic [6:0]  w_seg [6];
    logic [6:0]  w_disp [6];

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = SHIFT;
            SHIFT:   if (r_cnt == 5'd1) w_next_state = LATCH;
            LATCH:   w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Add-3 correction applied to every nibble before the shift
    always_comb begin
        w_bcd_adj = '0;
        w_nib     = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            w_nib = r_bcd[4*i +: 4];
            w_bcd_adj[4*i +: 4] = (w_nib >= 4'd5) ? w_nib + 4'd3 : w_nib;
        end
    end

    // w_lz[n]: digit n and every more-significant digit are zero
    always_comb begin
        w_lz    = '0;
        w_lz[5] = (r_bcd[23:20] == 4'd0);
        for (int unsigned i = 1; i <= 4; i++) begin
            w_lz[5-i] = w_lz[6-i] && (r_bcd[4*(5-i) +: 4] == 4'd0);
        end
        w_lz[0] = 1'b0;
    end

    generate
        for (genvar g = 0; g < 6; g++) begin : g_dec
            seg7_decode u_dec (
                .i_digit (r_bcd[4*g +: 4]),
                .o_seg   (w_seg[g])
            );
        end
    endgenerate

    always_comb begin
        for (int unsigned i = 0; i < 6; i++) begin
            w_disp[i] = ((BLANK_LZ != 0) && w_lz[i]) ? SEG_BLANK : w_seg[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_next <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            for (int unsigned i = 0; i < 6; i++) r_hex[i] <= SEG_BLANK;
        end else begin
            r_busy <= (r_state != IDLE);
            r_done <= (r_state == LATCH);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bin      <= (value > MAX_DISPLAY) ? MAX_DISPLAY : value;
                        r_ovf_next <= (value > MAX_DISPLAY);
                        r_bcd      <= '0;
                        r_cnt      <= 5'(SHIFT_COUNT);
                    end
                end
                SHIFT: begin
                    {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
                    r_cnt          <= r_cnt - 5'd1;
                end
                LATCH: begin
                    for (int unsigned i = 0; i < 6; i++) r_hex[i] <= w_disp[i];
                    r_ovf <= r_ovf_next;
                end
                default: ;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign ovf  = r_ovf;
    assign hex0 = r_hex[0];
    assign hex1 = r_hex[1];
    assign hex2 = r_hex[2];
    assign hex3 = r_hex[3];
    assign hex4 = r_hex[4];
    assign hex5 = r_hex[5];

endmodule

// File: doc/bcd_hex_display.md
BCD_HEX_DISPLAY -- requirements
Module: bcd_hex_display

Interface
REQ-001 Parameter BLANK_LZ, default 1, meaning: when 1, leading-zero digits are blanked (digit 0 is always shown).
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  single-cycle request to convert and display value; sampled on the rising edge of clk.
REQ-005 value  input  20  unsigned binary millisecond count from the ms counter.
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 done  output  1  one-cycle pulse when new digits appear on the HEX outputs.
REQ-008 ovf  output  1  high when the last converted value exceeded 999999.
REQ-009 hex0..hex5  output  7 each  active-low seven-segment patterns, bit order {g,f,e,d,c,b,a}; hex0 is the least significant digit.

Function
REQ-010 The FSM SHALL have three states: IDLE, SHIFT and LATCH.
REQ-011 In IDLE with start=1 at edge k, the block SHALL capture min(value, 999999), set an internal ovf_next flag to (value > 999999), clear the 24-bit BCD register, load a shift count of 20 and enter SHIFT.
REQ-012 In SHIFT, the block SHALL apply one double-dabble step per edge (edges k+1..k+20): add 3 to each BCD nibble >= 5, then shift {bcd, binary} left by 1.
REQ-013 After the 20th shift, the FSM SHALL enter LATCH; at edge k+21 it SHALL update hex0..hex5 and ovf, assert done for exactly one cycle and return to IDLE.
REQ-014 busy SHALL be high in the cycles after edges k+1 through k+21, and low otherwise.
REQ-015 start asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-016 start asserted in the cycle after done, with the FSM in IDLE, SHALL be accepted, giving a back-to-back period of 22 cycles.
REQ-017 HEX outputs SHALL hold their last latched patterns between conversions and during a conversion.
REQ-018 The digit encodings SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111.
REQ-019 With BLANK_LZ=1, digit n (n>=1) SHALL be blank when it and all more-significant digits are zero.
REQ-020 With BLANK_LZ=0, all six digits SHALL always be shown.
REQ-021 Nibble values 10-15 SHALL decode to blank; such values are unreachable in normal operation.

Reset
REQ-022 On a clock edge with reset_n=0, the block SHALL enter IDLE and clear the BCD register, shift count and ovf_next.
REQ-023 During reset, the outputs SHALL be: busy=0, done=0, ovf=0, and hex0..hex5=1111111.
REQ-024 Reset asserted during SHIFT or LATCH SHALL abort the conversion and SHALL produce no done pulse.
REQ-025 The first start after reset release SHALL be accepted normally.

Structure
REQ-026 The shared package SHALL hold the state enum (IDLE, SHIFT, LATCH), the constant MAX_DISPLAY=999999, the SEG_BLANK constant and the ten digit segment constants.
REQ-027 The digit-to-segment decode SHALL be a combinational sub-module seg7_decode (4-bit digit in, 7-bit pattern out), instantiated six times.
REQ-028 The FSM, shift register and blanking logic SHALL reside in bcd_hex_display.

Verification
REQ-029 value=0, start, BLANK_LZ=1 -> done at edge k+21; hex0=1000000; hex1..hex5=1111111; ovf=0.
REQ-030 value=123456, start -> done pulse exactly 1 cycle; hex5..hex0 = 1,2,3,4,5,6 patterns; busy high for 21 cycles.
REQ-031 value=1048575, start -> all six digits show 9 (0010000); ovf=1.
REQ-032 value=999999, start -> all six digits show 9; ovf=0.
REQ-033 Second start at k+5 with value=7 -> ignored; the display shows the first value; only one done pulse occurs.
REQ-034 reset_n=0 at edge k+10 during conversion of 500 -> busy=0, no done pulse, HEX all 1111111; a following start with 500 then shows blank,blank,blank,5,0,0.
